// File: rtl/ctrl_estac_pkg.sv
// Shared types and defaults for the parking-gate controller.
// Holds the 3-bit state encoding, default PIN and default limits.
package ctrl_estac_pkg;

  typedef enum logic [2:0] {
    ESPERA      = 3'd0,
    INGRESO_PIN = 3'd1,
    ALARMA_PIN  = 3'd2,
    ABIERTO     = 3'd3,
    BLOQUEO     = 3'd4
  } estado_t;

  localparam logic [7:0] PIN_DEF          = 8'b0001_0000;
  localparam int         MAX_INTENTOS_DEF = 3;
  localparam int         TIMEOUT_CYC_DEF  = 16;

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector with async active-high reset.
// Ports: i_clk, i_rst, i_d (level in), o_ev (one-cycle rise pulse).
module detector_flanco (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_ev
);

  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_ev = i_d & ~r_q;

endmodule

// File: rtl/controlador_estacionamiento_param.sv
// Parking-gate controller: PIN entry, wrong-attempt alarm, tailgate lock.
// Ports: Clk, Reset (async high), Vehiculo, Termino, enterPin, Pin in;
//        Cerrado, Abierto, Alarma, Bloqueo, Intentos out (all registered).
// Optional: `define CTRL_ESTAC_TIMEOUT_EN adds the open-gate auto-close.
module controlador_estacionamiento_param
  import ctrl_estac_pkg::*;
#(
  parameter int               PIN_W        = 8,
  parameter logic [PIN_W-1:0] PIN_CORRECTO = PIN_W'(PIN_DEF),
  parameter int               MAX_INTENTOS = MAX_INTENTOS_DEF,
  parameter int               TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int               CNT_W        = $clog2(MAX_INTENTOS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Vehiculo,
  input  logic             Termino,
  input  logic             enterPin,
  input  logic [PIN_W-1:0] Pin,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo,
  output logic [CNT_W-1:0] Intentos
);

  estado_t          r_estado;
  estado_t          w_sig;
  logic [CNT_W-1:0] r_intentos;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_sig_cnt;
  logic             w_pin_ev;
  logic             w_pin_ok;
  logic             w_tmo;
  logic             r_cerrado;
  logic             r_abierto;
  logic             r_alarma;
  logic             r_bloqueo;

  detector_flanco u_flanco (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_d   (enterPin),
    .o_ev  (w_pin_ev)
  );

  assign w_pin_ok = (Pin == PIN_CORRECTO);

  // Saturating increment: never wraps past the limit
  assign w_cnt_inc = (int'(r_intentos) >= MAX_INTENTOS)
                   ? r_intentos
                   : r_intentos + CNT_W'(1);

`ifdef CTRL_ESTAC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo;

  // Held at zero outside ABIERTO so every entry starts fresh;
  // a present vehicle keeps restarting the wait.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_tmo <= '0;
    else if (r_estado != ABIERTO || Vehiculo)
      r_tmo <= '0;
    else
      r_tmo <= r_tmo + TMO_W'(1);
  end

  // Fires on the edge where the idle count reaches TIMEOUT_CYC
  assign w_tmo = !Vehiculo && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
`else
  // No auto-close: constant false
  assign w_tmo = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    w_sig     = r_estado;
    w_sig_cnt = r_intentos;
    case (r_estado)
      ESPERA: begin
        if (Vehiculo) w_sig = INGRESO_PIN;
      end
      INGRESO_PIN: begin
        // A PIN event beats a vehicle backing away
        if (w_pin_ev) begin
          if (w_pin_ok) begin
            w_sig     = ABIERTO;
            w_sig_cnt = '0;
          end else begin
            w_sig_cnt = w_cnt_inc;
            if (int'(w_cnt_inc) >= MAX_INTENTOS)
              w_sig = ALARMA_PIN;
          end
        end else if (!Vehiculo) begin
          w_sig = ESPERA;
        end
      end
      ALARMA_PIN: begin
        if (w_pin_ev) begin
          if (w_pin_ok) begin
            w_sig     = ABIERTO;
            w_sig_cnt = '0;
          end else begin
            w_sig_cnt = w_cnt_inc;
          end
        end
      end
      ABIERTO: begin
        if (Vehiculo && Termino) w_sig = BLOQUEO;
        else if (Termino)        w_sig = ESPERA;
        else if (w_tmo)          w_sig = ESPERA;
      end
      BLOQUEO: begin
        if (w_pin_ev && w_pin_ok) w_sig = ESPERA;
      end
      default: w_sig = ESPERA;
    endcase
  end

  // Outputs decoded from the next state so they move with it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_estado   <= ESPERA;
      r_intentos <= '0;
      r_cerrado  <= 1'b1;
      r_abierto  <= 1'b0;
      r_alarma   <= 1'b0;
      r_bloqueo  <= 1'b0;
    end else begin
      r_estado   <= w_sig;
      r_intentos <= w_sig_cnt;
      r_cerrado  <= (w_sig != ABIERTO);
      r_abierto  <= (w_sig == ABIERTO);
      r_alarma   <= (w_sig == ALARMA_PIN);
      r_bloqueo  <= (w_sig == BLOQUEO);
    end
  end

  assign Cerrado  = r_cerrado;
  assign Abierto  = r_abierto;
  assign Alarma   = r_alarma;
  assign Bloqueo  = r_bloqueo;
  assign Intentos = r_intentos;

endmodule

// File: doc/controlador_estacionamiento_param.md
Name: controlador_estacionamiento_param

Overview:
Parametrised successor of the parking-gate controller.
- Admits a vehicle on a correct PIN of configurable width.
- Counts wrong attempts up to a configurable limit and raises Alarma.
- Locks on tailgating (simultaneous arrival and finish).
- Optionally auto-closes the gate after a timeout.
- Sits between the gate sensors/keypad and the gate actuator.
- Driven by the existing probador-style bench.

Parameters:
PIN_W, 8, width of Pin bus
PIN_CORRECTO, 8'b00010000, accepted PIN value (PIN_W bits)
MAX_INTENTOS, 3, wrong attempts that raise the alarm; must be ≥1
TIMEOUT_CYC, 16, cycles the gate may stay open without Termino (used only with the optional feature)
CNT_W, $clog2(MAX_INTENTOS+1), attempt counter width (derived)

Ports:
Clk  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high
Vehiculo  input  1  vehicle present at gate
Termino  input  1  vehicle finished passing
enterPin  input  1  keypad enter; only its rising edge counts
Pin  input  PIN_W  PIN value, sampled on enterPin rising edge
Cerrado  output  1  gate closed
Abierto  output  1  gate open
Alarma  output  1  wrong-PIN alarm
Bloqueo  output  1  tailgate lock
Intentos  output  CNT_W  current wrong-attempt count

Behaviour:
- Reset (async, active-high): state = ESPERA, counter = 0.
  - Reset values: Cerrado=1, Abierto=0, Alarma=0, Bloqueo=0, Intentos=0.
  - Edge-detect register = 0.
  - Reset mid-operation aborts any state immediately.
- Edge detection: pin_ev = enterPin & ~enterPin_q.
  - A level held for many cycles is one event.
  - Pin changes while enterPin is low are ignored.
- Outputs are registered and change on the same Clk edge as the state transition (one cycle after inputs are sampled).
- States:
  - ESPERA
    - Outputs: Cerrado=1, others 0.
    - Vehiculo=1 → INGRESO_PIN.
    - enterPin is ignored.
  - INGRESO_PIN
    - Outputs: Cerrado=1, Alarma=0.
    - pin_ev with Pin==PIN_CORRECTO → ABIERTO; counter cleared.
    - pin_ev with wrong Pin → counter+1. If the new value is ≥MAX_INTENTOS → ALARMA_PIN, else stay.
    - Vehiculo=0 with no pin_ev → ESPERA. The counter is retained, so reversing away does not reset attempts.
    - pin_ev and a falling Vehiculo in the same cycle: pin evaluation wins.
  - ALARMA_PIN
    - Outputs: Cerrado=1, Alarma=1.
    - Further wrong pin_ev keeps the counter saturated at MAX_INTENTOS.
    - Correct pin_ev → ABIERTO; Alarma cleared; counter cleared.
    - Vehiculo falling does not exit this state.
  - ABIERTO
    - Outputs: Abierto=1, Cerrado=0.
    - Vehiculo=1 and Termino=1 in the same cycle → BLOQUEO. This check has priority over all other exits.
    - Termino=1 with Vehiculo=0 → ESPERA.
    - pin_ev is ignored.
  - BLOQUEO
    - Outputs: Cerrado=1, Bloqueo=1, Alarma=0.
    - Only a correct pin_ev exits, to ESPERA with Bloqueo cleared.
    - Wrong pins are ignored and do not increment the counter.
- Invariant: Cerrado and Abierto are mutually exclusive.
- Counter saturates and never wraps.
- Pin comparison is a full PIN_W-bit equality.
- Illegal state encoding → ESPERA.

Optional Feature:
- Macro: CTRL_ESTAC_TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT_CYC+1) runs while in ABIERTO.
  - It is cleared on entry and on any cycle Vehiculo=1.
  - When it reaches TIMEOUT_CYC with Termino=0 → ESPERA (gate closes).
  - A tailgate (Vehiculo=1, Termino=1) in the same cycle takes priority.
- Undefined: ABIERTO persists indefinitely until Termino or a tailgate; no counter is synthesised.

Decomposition:
- Shared package ctrl_estac_pkg holds:
  - state encoding localparams: ESPERA, INGRESO_PIN, ALARMA_PIN, ABIERTO, BLOQUEO (3-bit);
  - default PIN constant;
  - default MAX_INTENTOS and TIMEOUT_CYC.
- One natural sub-module: detector_flanco (rising-edge detector with async reset), reusable for enterPin and future keypad inputs.

Test Plan:
- Reset pulse at 5–15 → Cerrado=1, Abierto=Alarma=Bloqueo=0, Intentos=0. Asserting Reset while in ABIERTO forces Cerrado=1 with no clock edge.
- Vehiculo=1, Pin=8'hFF with enterPin held high 3 cycles → Intentos=1 only (single event), no Alarma. Changing Pin to 0 with enterPin low → no change.
- Three wrong pin_ev (8'hFF), then a 4th wrong one → Alarma=1 after the 3rd, Intentos stays 3. Pin=8'h10 pin_ev → Abierto=1, Alarma=0, Intentos=0 on the next edge.
- In ABIERTO, {Vehiculo,Termino}=2'b01 → Cerrado=1 (ESPERA). A new Vehiculo, one wrong pin, then the correct pin → Intentos 1→0, Abierto=1, no Alarma.
- In ABIERTO, Vehiculo=Termino=1 in the same cycle → Bloqueo=1, Cerrado=1. A wrong pin keeps Bloqueo and Intentos unchanged. Correct pin → Bloqueo=0, ESPERA.
- With CTRL_ESTAC_TIMEOUT_EN and TIMEOUT_CYC=4: open the gate, drop Vehiculo, keep Termino=0 → Cerrado=1 exactly 4 cycles later. Without the macro → Abierto=1 remains after 20 cycles.
